// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_XLEN   = 32;
  localparam int unsigned MULDIV_CYCLES = MULDIV_XLEN;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide on
// magnitudes, with sign fix-up applied to the value produced by each step.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MULDIV_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  muldiv_op_t      op_q, op_in;
  logic [XLEN-1:0] dvs_q;
  logic            neg_q, rem_neg_q;
  logic [2*XLEN:0] acc_q, acc_d, step_val;

  logic            sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  logic [XLEN:0]   mul_sum, div_shift, div_rem;
  logic            div_trial;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo, rem;
  logic            unused_top;

  always_comb begin
    op_in = muldiv_op_t'(funct3_i);
    sgn_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    sgn_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    neg_a = sgn_a & a_i[XLEN-1];
    neg_b = sgn_b & b_i[XLEN-1];
    mag_a = neg_a ? (~a_i + 1'b1) : a_i;
    mag_b = neg_b ? (~b_i + 1'b1) : b_i;
  end

  // Multiply keeps the multiplier in the low half and shifts the partial
  // product in from the top; divide keeps {remainder, quotient} instead.
  always_comb begin
    mul_sum   = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_shift >= {1'b0, dvs_q};
    div_rem   = div_trial ? (div_shift - {1'b0, dvs_q}) : div_shift;
    if (op_is_div(op_q)) begin
      step_val = {div_rem, acc_q[XLEN-2:0], div_trial};
    end else begin
      step_val = {1'b0, mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = step_val[2*XLEN-1:0];
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    quo      = step_val[XLEN-1:0];
    rem      = step_val[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                       result_o = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result_o = neg_q ? (~quo + 1'b1) : quo;
      default:                      result_o = rem_neg_q ? (~rem + 1'b1) : rem;
    endcase
  end

  assign unused_top = step_val[2*XLEN];

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = op_is_div(op_in) ? {{(XLEN+1){1'b0}}, mag_a} : {{(XLEN+1){1'b0}}, mag_b};
    end else if (step_i) begin
      acc_d = step_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q      <= OP_MUL;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      acc_q <= acc_d;
      if (load_i) begin
        op_q      <= op_in;
        dvs_q     <= op_is_div(op_in) ? mag_b : mag_a;
        neg_q     <= neg_a ^ neg_b;
        rem_neg_q <= neg_a;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit for Execute: FSM, iteration counter, divide
// special-case bypass and the stall/done handshake with the hazard unit.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MULDIV_XLEN
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_StartE,
  input  logic [2:0]      i_Funct3E,
  input  logic [XLEN-1:0] i_SrcAE,
  input  logic [XLEN-1:0] i_SrcBE,
  input  logic            i_FlushE,
  output logic            o_StallReq,
  output logic            o_DoneE,
  output logic [XLEN-1:0] o_ResultE
);

  localparam int unsigned CW = $clog2(XLEN);

  muldiv_state_t   state_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            start_ok, core_step;
  logic            is_div, is_rem, is_signed_div, b_zero, ovf, special;
  logic [XLEN-1:0] spec_result, core_result;
  logic [XLEN-1:0] int_min;

  always_comb begin
    int_min       = '0;
    int_min[XLEN-1] = 1'b1;
    is_div        = i_Funct3E[2];
    is_rem        = i_Funct3E[1];
    is_signed_div = ~i_Funct3E[0];
    b_zero        = (i_SrcBE == '0);
    ovf           = is_signed_div && (i_SrcAE == int_min) && (i_SrcBE == '1);
    special       = is_div && (b_zero || ovf);
    if (b_zero) begin
      spec_result = is_rem ? i_SrcAE : '1;
    end else begin
      spec_result = is_rem ? '0 : int_min;
    end
  end

  assign start_ok   = (state_q == IDLE) && i_StartE && !i_FlushE;
  assign core_step  = (state_q == BUSY) && !i_FlushE;
  assign o_StallReq = i_StartE && !i_FlushE && ((state_q == IDLE) || (state_q == BUSY));
  assign o_DoneE    = done_q;
  assign o_ResultE  = result_q;

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk_i    (i_clk),
    .rst_i    (i_reset),
    .load_i   (start_ok),
    .step_i   (core_step),
    .funct3_i (i_Funct3E),
    .a_i      (i_SrcAE),
    .b_i      (i_SrcBE),
    .result_o (core_result)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (i_FlushE) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_StartE) begin
            if (special) begin
              result_q <= spec_result;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              cnt_q   <= CW'(XLEN - 1);
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          // The final step's output is captured directly, so DONE shows the
          // result without an extra fix-up cycle.
          if (cnt_q == '0) begin
            result_q <= core_result;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] srca, srcb;
  logic        flush;
  logic        stall, done;
  logic [31:0] res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_StartE   (start),
    .i_Funct3E  (funct3),
    .i_SrcAE    (srca),
    .i_SrcBE    (srcb),
    .i_FlushE   (flush),
    .o_StallReq (stall),
    .o_DoneE    (done),
    .o_ResultE  (res)
  );

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint p;
    int ia = $signed(a);
    int ib = $signed(b);
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int stalls, exp_stalls;
    bit got;
    exp = ref_model(f, a, b);
    exp_stalls = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; srca = a; srcb = b;
    stalls = 0; got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        checks++;
        if (res !== exp) begin
          errors++;
          $display("FAIL %s result f=%0d a=%h b=%h: got %h expected %h", tag, f, a, b, res, exp);
        end
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_in_done: got %b expected 0", tag, stall);
        end
      end else if (stall) begin
        stalls++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within 100 cycles, expected done", tag);
    end
    checks++;
    if (stalls != exp_stalls) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stalls, exp_stalls);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: done still %b one cycle later, expected 0", tag, done);
    end
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    bit bad_done = 0, bad_stall = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done !== 1'b0) bad_done = 1;
      if (stall !== 1'b0) bad_stall = 1;
    end
    checks++;
    if (bad_done) begin errors++; $display("FAIL %s no_done: got done=1 expected 0", tag); end
    checks++;
    if (bad_stall) begin errors++; $display("FAIL %s no_stall: got stall=1 expected 0", tag); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; srca = '0; srcb = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, done, res} !== 34'h0) begin
      errors++;
      $display("FAIL reset_state: got stall=%b done=%b res=%h expected all 0", stall, done, res);
    end
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu_m1_2");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, "remu_100_7");
  endtask

  task automatic test_special();
    run_op(3'd4, 32'd5, 32'd0, "div_by_0");
    run_op(3'd6, 32'd5, 32'd0, "rem_by_0");
    run_op(3'd5, 32'd5, 32'd0, "divu_by_0");
    run_op(3'd7, 32'd5, 32'd0, "remu_by_0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, "divu_not_ovf");
  endtask

  task automatic test_flush();
    bit busy_ok = 1;
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd0; srca = 32'd123; srcb = 32'd456;
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 10) flush = 1'b1;
      @(negedge clk);
      if (i < 10 && stall !== 1'b1) busy_ok = 0;
    end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL flush_busy_stall: stall dropped before flush, expected 1"); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_same_cycle: got stall=%b expected 0", stall); end
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    expect_quiet(40, "flush_busy");
    // Flush arriving together with a start in IDLE.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = 3'd4; srca = 32'd9; srcb = 32'd0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_start: got stall=%b expected 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    expect_quiet(5, "flush_idle");
    run_op(3'd0, 32'd3, 32'd4, "mul_after_flush");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd5; srca = 32'hDEAD_BEEF; srcb = 32'd13;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin reset = 1'b1; start = 1'b0; end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, done, res} !== 34'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got stall=%b done=%b res=%h expected all 0", stall, done, res);
    end
    expect_quiet(40, "reset_mid");
    run_op(3'd0, 32'd3, 32'd4, "mul_after_reset");
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int n = 0; n < 30; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(f, a, b, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_mul");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_mulh");
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, "b2b_rem");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
